jk_excitation_driver: RTL and testbench

- Drives the J/K inputs of an external WIDTH-bit bank of master-slave JK flip-flops, so that the bank steps to a commanded next state.
- Holds a shadow copy of the bank state and uses the JK excitation table to turn the current→next state change into J/K values per bit.
- Checks the bank's fed-back Q against the expected state after a settle delay, and flags any mismatch.
- Sits between the control logic and the JK register bank: the JK flop receives J/K, this block generates them.

---
 rtl/jk_excitation_driver.sv | 149 ++++++++++++++
 tb/tb_jk_excitation_driver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// JK excitation driver: steps an external JK bank to a commanded state and checks Q feedback.
// Optional JK_TOGGLE_PREF_EN resolves excitation don't-cares to 1 (toggle path).
module jk_excitation_driver #(
  parameter int WIDTH  = 4,
  parameter int FB_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q_exp,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  localparam int CW = (FB_LAT > 1) ? $clog2(FB_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FB_LAT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_DEC  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] qexp_q, qexp_d;
  logic [WIDTH-1:0] nxt_q, nxt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             load_q, load_d;
  logic             armed_q, armed_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] nxt_sel;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;
  logic             accept;
  logic             last;
  logic             mism;

  always_comb begin
    nxt_sel = qexp_q;
    unique case (cmd_op)
      OP_HOLD: nxt_sel = qexp_q;
      OP_LOAD: nxt_sel = cmd_data;
      OP_INC:  nxt_sel = qexp_q + WIDTH'(1);
      OP_DEC:  nxt_sel = qexp_q - WIDTH'(1);
      default: nxt_sel = qexp_q;
    endcase
  end

`ifdef JK_TOGGLE_PREF_EN
  assign exc_j = qexp_q | nxt_sel;
  assign exc_k = ~(qexp_q & nxt_sel);
`else
  assign exc_j = ~qexp_q & nxt_sel;
  assign exc_k = qexp_q & ~nxt_sel;
`endif

  assign accept = cmd_valid && (state_q == S_IDLE);
  assign last   = (state_q == S_SETTLE) && (cnt_q == CNT_LAST);
  // X/Z on the feedback must count as a mismatch
  assign mism   = (q_fb !== qexp_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qexp_d  = qexp_q;
    nxt_d   = nxt_q;
    j_d     = '0;
    k_d     = '0;
    load_d  = load_q;
    armed_d = armed_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (accept) begin
          nxt_d   = nxt_sel;
          load_d  = (cmd_op == OP_LOAD);
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = S_DRIVE;
        end
      end
      (state_q == S_DRIVE): begin
        qexp_d  = nxt_q;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      (state_q == S_SETTLE): begin
        if (last) begin
          state_d = S_IDLE;
          if (load_q) armed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A failing check in the same cycle as err_clr keeps err set
  always_comb begin
    err_d = err_q;
    if (last && armed_q && mism) err_d = 1'b1;
    else if (err_clr && !last)   err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      qexp_q  <= '0;
      nxt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      load_q  <= 1'b0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qexp_q  <= qexp_d;
      nxt_q   <= nxt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      load_q  <= load_d;
      armed_q <= armed_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign j         = j_q;
  assign k         = k_q;
  assign q_exp     = qexp_q;
  assign done      = last;
  assign err       = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver with a behavioural JK bank model.
// Bank feedback lags the DRIVE cycle by FB_LAT cycles and can be overridden.
module tb_jk_excitation_driver;

  localparam int W  = 4;
  localparam int FL = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] j, k, q_exp, q_fb;
  logic         done, err, err_clr;

  logic [W-1:0] bank_q, pipe_q, ovr_val;
  logic         ovr_en;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jk_excitation_driver #(.WIDTH(W), .FB_LAT(FL)) dut (
    .clk(clk), .reset(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .j(j), .k(k), .q_exp(q_exp), .q_fb(q_fb),
    .done(done), .err(err), .err_clr(err_clr)
  );

  // JK bank plus one extra pipeline stage => feedback valid FL cycles after DRIVE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
      pipe_q <= '0;
    end else begin
      bank_q <= (j & ~bank_q) | (~k & bank_q);
      pipe_q <= bank_q;
    end
  end

  assign q_fb = ovr_en ? ovr_val : pipe_q;

  task automatic issue(input logic [1:0] op, input logic [W-1:0] d,
                       output logic [W-1:0] jd, output logic [W-1:0] kd,
                       output logic rdy);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1;
    jd  = j;
    kd  = k;
    rdy = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 4'b0110;
  endtask

  task automatic wait_done(output int n, output logic seen);
    seen = 1'b0;
    n    = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
    err_clr = 1'b0; ovr_en = 1'b0; ovr_val = '0;
    #2;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", cmd_ready); end
    checks++; if (j !== 4'b0000) begin errors++; $display("FAIL rst_j got %b want 0000", j); end
    checks++; if (k !== 4'b0000) begin errors++; $display("FAIL rst_k got %b want 0000", k); end
    checks++; if (q_exp !== 4'b0000) begin errors++; $display("FAIL rst_qexp got %b want 0000", q_exp); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load;
    logic [W-1:0] jd, kd; logic rdy, seen; int n;
    issue(2'b01, 4'b1010, jd, kd, rdy);
    checks++; if (jd !== 4'b1010) begin errors++; $display("FAIL load_j got %b want 1010", jd); end
    checks++; if (kd !== 4'b0000) begin errors++; $display("FAIL load_k got %b want 0000", kd); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL load_busy got %b want 0", rdy); end
    wait_done(n, seen);
    checks++; if (!seen || n != FL) begin errors++; $display("FAIL load_done seen=%b cycles=%0d want 1/%0d", seen, n, FL); end
    checks++; if (q_exp !== 4'b1010) begin errors++; $display("FAIL load_qexp got %b want 1010", q_exp); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_err got %b want 0", err); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL load_idle got %b want 1", cmd_ready); end
  endtask

  task automatic test_load_swap;
    logic [W-1:0] jd, kd; logic rdy, seen; int n;
    issue(2'b01, 4'b0101, jd, kd, rdy);
    checks++; if (jd !== 4'b0101) begin errors++; $display("FAIL swap_j got %b want 0101", jd); end
    checks++; if (kd !== 4'b1010) begin errors++; $display("FAIL swap_k got %b want 1010", kd); end
    wait_done(n, seen);
    checks++; if (q_exp !== 4'b0101) begin errors++; $display("FAIL swap_qexp got %b want 0101", q_exp); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL swap_err got %b want 0", err); end
  endtask

  task automatic test_inc;
    logic [W-1:0] jd, kd; logic rdy, seen; int n;
    issue(2'b01, 4'b1010, jd, kd, rdy);
    checks++; if (kd !== 4'b0101) begin errors++; $display("FAIL reload_k got %b want 0101", kd); end
    wait_done(n, seen);
    issue(2'b10, 4'b1111, jd, kd, rdy);
    checks++; if (jd !== 4'b0001) begin errors++; $display("FAIL inc_j got %b want 0001", jd); end
    checks++; if (kd !== 4'b0000) begin errors++; $display("FAIL inc_k got %b want 0000", kd); end
    wait_done(n, seen);
    checks++; if (q_exp !== 4'b1011) begin errors++; $display("FAIL inc_qexp got %b want 1011", q_exp); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL inc_err got %b want 0", err); end
  endtask

  task automatic test_wrap;
    logic [W-1:0] jd, kd; logic rdy, seen; int n;
    issue(2'b01, 4'b1111, jd, kd, rdy);
    wait_done(n, seen);
    issue(2'b10, 4'b0000, jd, kd, rdy);
    checks++; if (jd !== 4'b0000) begin errors++; $display("FAIL incwrap_j got %b want 0000", jd); end
    checks++; if (kd !== 4'b1111) begin errors++; $display("FAIL incwrap_k got %b want 1111", kd); end
    wait_done(n, seen);
    checks++; if (q_exp !== 4'b0000) begin errors++; $display("FAIL incwrap_qexp got %b want 0000", q_exp); end
    issue(2'b11, 4'b0101, jd, kd, rdy);
    checks++; if (jd !== 4'b1111) begin errors++; $display("FAIL decwrap_j got %b want 1111", jd); end
    checks++; if (kd !== 4'b0000) begin errors++; $display("FAIL decwrap_k got %b want 0000", kd); end
    wait_done(n, seen);
    checks++; if (q_exp !== 4'b1111) begin errors++; $display("FAIL decwrap_qexp got %b want 1111", q_exp); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err got %b want 0", err); end
  endtask

  task automatic test_hold;
    logic [W-1:0] jd, kd; logic rdy, seen; int n;
    issue(2'b00, 4'b0000, jd, kd, rdy);
    checks++; if (jd !== 4'b0000 || kd !== 4'b0000) begin errors++; $display("FAIL hold_jk got %b/%b want 0000/0000", jd, kd); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL hold_busy got %b want 0", rdy); end
    wait_done(n, seen);
    checks++; if (!seen || n != FL) begin errors++; $display("FAIL hold_done seen=%b cycles=%0d want 1/%0d", seen, n, FL); end
    checks++; if (q_exp !== 4'b1111) begin errors++; $display("FAIL hold_qexp got %b want 1111", q_exp); end
  endtask

  task automatic test_mask;
    logic [W-1:0] jd, kd; logic rdy, seen; int n;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    ovr_en = 1'b1; ovr_val = 4'bxxxx;
    issue(2'b10, 4'b0000, jd, kd, rdy);
    wait_done(n, seen);
    checks++; if (!seen) begin errors++; $display("FAIL mask_inc_done got 0 want 1"); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mask_inc_err got %b want 0", err); end
    issue(2'b00, 4'b0000, jd, kd, rdy);
    wait_done(n, seen);
    checks++; if (!seen || err !== 1'b0) begin errors++; $display("FAIL mask_hold seen=%b err=%b want 1/0", seen, err); end
    ovr_en = 1'b0;
    issue(2'b01, 4'b0101, jd, kd, rdy);
    wait_done(n, seen);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mask_load1_err got %b want 0", err); end
    ovr_en = 1'b1; ovr_val = 4'b0011;
    issue(2'b01, 4'b0101, jd, kd, rdy);
    wait_done(n, seen);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mism_err got %b want 1", err); end
    // err_clr held across a failing check: set must win
    err_clr = 1'b1;
    issue(2'b00, 4'b0000, jd, kd, rdy);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_busy_err got %b want 0", err); end
    wait_done(n, seen);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL setwins_err got %b want 1", err); end
    @(negedge clk); err_clr = 1'b0;
    ovr_en = 1'b0;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_err got %b want 0", err); end
  endtask

  task automatic test_busy;
    logic seen; int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'b0011;
    @(posedge clk); #1;
    checks++; if (j !== 4'b0010 || k !== 4'b0100) begin errors++; $display("FAIL busy_drv1 got %b/%b want 0010/0100", j, k); end
    @(negedge clk); cmd_data = 4'b1100;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_settle0 got %b want 0", cmd_ready); end
    @(negedge clk); cmd_data = 4'b1110;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL busy_settle1 rdy=%b done=%b want 0/1", cmd_ready, done); end
    @(negedge clk); cmd_data = 4'b1111;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL busy_idle got %b want 1", cmd_ready); end
    checks++; if (q_exp !== 4'b0011) begin errors++; $display("FAIL busy_qexp1 got %b want 0011", q_exp); end
    @(posedge clk); #1;
    checks++; if (j !== 4'b1100 || k !== 4'b0000) begin errors++; $display("FAIL busy_drv2 got %b/%b want 1100/0000", j, k); end
    @(negedge clk); cmd_valid = 1'b0;
    wait_done(n, seen);
    checks++; if (q_exp !== 4'b1111 || err !== 1'b0) begin errors++; $display("FAIL busy_qexp2 got %b err=%b want 1111/0", q_exp, err); end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] jd, kd; logic rdy, seen; int n;
    issue(2'b01, 4'b0000, jd, kd, rdy);
    checks++; if (kd !== 4'b1111) begin errors++; $display("FAIL mid_drv_k got %b want 1111", kd); end
    rst_n = 1'b0;
    #1;
    checks++; if (j !== 4'b0000 || k !== 4'b0000) begin errors++; $display("FAIL mid_jk got %b/%b want 0000/0000", j, k); end
    checks++; if (q_exp !== 4'b0000) begin errors++; $display("FAIL mid_qexp got %b want 0000", q_exp); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", cmd_ready); end
    @(negedge clk); rst_n = 1'b1;
    ovr_en = 1'b1; ovr_val = 4'b1111;
    issue(2'b10, 4'b0000, jd, kd, rdy);
    wait_done(n, seen);
    checks++; if (q_exp !== 4'b0001 || err !== 1'b0) begin errors++; $display("FAIL mid_disarm got %b err=%b want 0001/0", q_exp, err); end
    ovr_en = 1'b0;
  endtask

  task automatic test_toggle;
    logic [W-1:0] jd, kd; logic rdy, seen; int n;
    issue(2'b01, 4'b1010, jd, kd, rdy);
    checks++; if (jd !== 4'b1010 || kd !== 4'b1111) begin errors++; $display("FAIL tog_load1 got %b/%b want 1010/1111", jd, kd); end
    wait_done(n, seen);
    issue(2'b01, 4'b0110, jd, kd, rdy);
    checks++; if (jd !== 4'b1110) begin errors++; $display("FAIL tog_j got %b want 1110", jd); end
    checks++; if (kd !== 4'b1101) begin errors++; $display("FAIL tog_k got %b want 1101", kd); end
    wait_done(n, seen);
    checks++; if (q_exp !== 4'b0110) begin errors++; $display("FAIL tog_qexp got %b want 0110", q_exp); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tog_err got %b want 0", err); end
  endtask

  initial begin
    test_reset;
`ifdef JK_TOGGLE_PREF_EN
    test_toggle;
`else
    test_load;
    test_load_swap;
    test_inc;
    test_wrap;
    test_hold;
    test_mask;
    test_busy;
    test_reset_mid;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
